// File: rtl/instr_exec.sv
// PDP-8 execution stage: runs memory-reference and group-1 operate
// instructions handed over by decode, owns AC/Link/PC and paces fetch
// through a registered stall.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package instr_exec_pkg;
  // one-hot memory-reference opcode from decode (AND is the MSB)
  typedef struct packed {
    logic AND;
    logic TAD;
    logic ISZ;
    logic DCA;
    logic JMS;
    logic JMP;
    logic NOP;
  } pdp_mem_opcode_s;

  // group-1 operate micro-op bits (CLA is the MSB)
  typedef struct packed {
    logic CLA;
    logic CLL;
    logic CMA;
    logic CML;
    logic IAC;
    logic RAR;
    logic RTR;
    logic RAL;
    logic RTL;
    logic HLT;
    logic NOP;
  } pdp_op7_opcode_s;
endpackage

module instr_exec
  import instr_exec_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(12'o0200)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_s       pdp_mem_opcode,
  input  pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  exec_rd_req,
  output logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_wr_req,
  output logic [ADDR_WIDTH-1:0] exec_wr_addr,
  output logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic [DATA_WIDTH-1:0] intAcc,
  output logic                  intLink
);

  typedef enum logic [2:0] {
    S_READY,
    S_RD_REQ,
    S_RD_WAIT,
    S_WRITE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_AND,
    OP_TAD,
    OP_ISZ,
    OP_DCA,
    OP_JMS,
    OP_JMP,
    OP_OP7
  } op_e;

  state_e                state_q;
  op_e                   op_q;
  pdp_op7_opcode_s       op7_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  link_q;
  logic                  stall_q;
  logic                  rd_req_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  wr_req_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic                  mem_any;
  logic                  op7_any;
  logic                  accept;
  op_e                   sel_op;
  logic [ADDR_WIDTH-1:0] pc_inc1;
  logic [ADDR_WIDTH-1:0] pc_inc2;
  logic [ADDR_WIDTH-1:0] jms_target;
  logic [DATA_WIDTH:0]   tad_sum;
  logic [DATA_WIDTH-1:0] isz_val;
  logic [DATA_WIDTH-1:0] op7_acc_d;
  logic                  op7_link_d;

  // NOP bits only matter in that they never make an instruction acceptable
  logic unused_nop;
  assign unused_nop = pdp_mem_opcode.NOP ^ pdp_op7_opcode.NOP ^ op7_q.NOP;

  assign stall        = stall_q;
  assign PC_value     = pc_q;
  assign exec_rd_req  = rd_req_q;
  assign exec_rd_addr = rd_addr_q;
  assign exec_wr_req  = wr_req_q;
  assign exec_wr_addr = wr_addr_q;
  assign exec_wr_data = wr_data_q;
  assign intAcc       = acc_q;
  assign intLink      = link_q;

  assign pc_inc1    = pc_q + ADDR_WIDTH'(1);
  assign pc_inc2    = pc_q + ADDR_WIDTH'(2);
  assign jms_target = addr_q + ADDR_WIDTH'(1);
  assign tad_sum    = {1'b0, acc_q} + {1'b0, exec_rd_data};
  assign isz_val    = exec_rd_data + DATA_WIDTH'(1);

  // accept qualification and memory-op priority AND>TAD>ISZ>DCA>JMS>JMP>op7
  always_comb begin
    mem_any = pdp_mem_opcode.AND | pdp_mem_opcode.TAD | pdp_mem_opcode.ISZ |
              pdp_mem_opcode.DCA | pdp_mem_opcode.JMS | pdp_mem_opcode.JMP;
    op7_any = pdp_op7_opcode.CLA | pdp_op7_opcode.CLL | pdp_op7_opcode.CMA |
              pdp_op7_opcode.CML | pdp_op7_opcode.IAC | pdp_op7_opcode.RAR |
              pdp_op7_opcode.RTR | pdp_op7_opcode.RAL | pdp_op7_opcode.RTL |
              pdp_op7_opcode.HLT;
    accept  = (state_q == S_READY) && !stall_q && (mem_any || op7_any);
    sel_op  = OP_OP7;
    if (pdp_mem_opcode.AND)      sel_op = OP_AND;
    else if (pdp_mem_opcode.TAD) sel_op = OP_TAD;
    else if (pdp_mem_opcode.ISZ) sel_op = OP_ISZ;
    else if (pdp_mem_opcode.DCA) sel_op = OP_DCA;
    else if (pdp_mem_opcode.JMS) sel_op = OP_JMS;
    else if (pdp_mem_opcode.JMP) sel_op = OP_JMP;
  end

  // group-1 operate datapath: clear, complement, increment, then one rotate
  always_comb begin
    logic [DATA_WIDTH-1:0] ac;
    logic                  lk;
    logic [DATA_WIDTH:0]   iac_sum;
    logic [DATA_WIDTH:0]   rot;
    ac      = acc_q;
    lk      = link_q;
    iac_sum = '0;
    if (op7_q.CLA) ac = '0;
    if (op7_q.CLL) lk = 1'b0;
    if (op7_q.CMA) ac = ~ac;
    if (op7_q.CML) lk = ~lk;
    if (op7_q.IAC) begin
      iac_sum = {1'b0, ac} + {{DATA_WIDTH{1'b0}}, 1'b1};
      ac      = iac_sum[DATA_WIDTH-1:0];
      if (iac_sum[DATA_WIDTH]) lk = ~lk;
    end
    rot = {lk, ac};
    if (op7_q.RAR)      rot = {rot[0], rot[DATA_WIDTH:1]};
    else if (op7_q.RTR) rot = {rot[1:0], rot[DATA_WIDTH:2]};
    else if (op7_q.RAL) rot = {rot[DATA_WIDTH-1:0], rot[DATA_WIDTH]};
    else if (op7_q.RTL) rot = {rot[DATA_WIDTH-2:0], rot[DATA_WIDTH:DATA_WIDTH-1]};
    op7_acc_d  = rot[DATA_WIDTH-1:0];
    op7_link_d = rot[DATA_WIDTH];
  end

  // execution FSM; strobes are single-cycle pulses, stall mirrors state != READY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_READY;
      op_q      <= OP_OP7;
      op7_q     <= '0;
      addr_q    <= '0;
      pc_q      <= START_PC;
      acc_q     <= '0;
      link_q    <= 1'b0;
      stall_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      case (state_q)
        S_READY: begin
          if (accept) begin
            addr_q  <= base_addr;
            op_q    <= sel_op;
            op7_q   <= pdp_op7_opcode;
            stall_q <= 1'b1;
            case (sel_op)
              OP_AND, OP_TAD, OP_ISZ: begin
                state_q   <= S_RD_REQ;
                rd_req_q  <= 1'b1;
                rd_addr_q <= base_addr;
              end
              OP_DCA: begin
                state_q   <= S_WRITE;
                wr_req_q  <= 1'b1;
                wr_addr_q <= base_addr;
                wr_data_q <= acc_q;
              end
              OP_JMS: begin
                state_q   <= S_WRITE;
                wr_req_q  <= 1'b1;
                wr_addr_q <= base_addr;
                wr_data_q <= DATA_WIDTH'(pc_inc1);
              end
              default: state_q <= S_EXEC;
            endcase
          end
        end
        S_RD_REQ: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          case (op_q)
            OP_AND: begin
              acc_q   <= acc_q & exec_rd_data;
              pc_q    <= pc_inc1;
              state_q <= S_READY;
              stall_q <= 1'b0;
            end
            OP_TAD: begin
              acc_q   <= tad_sum[DATA_WIDTH-1:0];
              link_q  <= link_q ^ tad_sum[DATA_WIDTH];
              pc_q    <= pc_inc1;
              state_q <= S_READY;
              stall_q <= 1'b0;
            end
            default: begin
              state_q   <= S_WRITE;
              wr_req_q  <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= isz_val;
            end
          endcase
        end
        S_WRITE: begin
          case (op_q)
            OP_DCA: begin
              acc_q <= '0;
              pc_q  <= pc_inc1;
            end
            OP_JMS:  pc_q <= jms_target;
            default: pc_q <= (wr_data_q == '0) ? pc_inc2 : pc_inc1;
          endcase
          state_q <= S_READY;
          stall_q <= 1'b0;
        end
        S_EXEC: begin
          if (op_q == OP_JMP) begin
            pc_q    <= addr_q;
            state_q <= S_READY;
            stall_q <= 1'b0;
          end else begin
            acc_q  <= op7_acc_d;
            link_q <= op7_link_d;
            pc_q   <= pc_inc1;
            if (op7_q.HLT) begin
              state_q <= S_HALT;
            end else begin
              state_q <= S_READY;
              stall_q <= 1'b0;
            end
          end
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q <= S_READY;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec.sv
// Scoreboard bench for instr_exec: stimulus pushes expected memory strobes
// and instruction completions; a negedge monitor pops and compares them.
module tb_instr_exec;
  import instr_exec_pkg::*;

  localparam logic [10:0] O_CLA = 11'b10000000000;
  localparam logic [10:0] O_CLL = 11'b01000000000;
  localparam logic [10:0] O_CMA = 11'b00100000000;
  localparam logic [10:0] O_IAC = 11'b00001000000;
  localparam logic [10:0] O_RTL = 11'b00000000100;
  localparam logic [10:0] O_HLT = 11'b00000000010;
  localparam int I_AND = 0, I_TAD = 1, I_ISZ = 2, I_DCA = 3, I_JMS = 4, I_JMP = 5;
  localparam int EV_RD = 0, EV_WR = 1, EV_DONE = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [11:0]     base_addr = '0;
  pdp_mem_opcode_s mem_op = '0;
  pdp_op7_opcode_s op7_op = '0;
  logic            stall;
  logic [11:0]     PC_value;
  logic            exec_rd_req;
  logic [11:0]     exec_rd_addr;
  logic [11:0]     exec_rd_data;
  logic            exec_wr_req;
  logic [11:0]     exec_wr_addr;
  logic [11:0]     exec_wr_data;
  logic [11:0]     intAcc;
  logic            intLink;

  always #5 clk = ~clk;

  instr_exec dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .pdp_mem_opcode(mem_op), .pdp_op7_opcode(op7_op),
    .stall(stall), .PC_value(PC_value),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .intAcc(intAcc), .intLink(intLink)
  );

  // memory seen by the DUT; the bench preloads it through the poke port
  logic [11:0] env_mem [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [11:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_en) env_mem[poke_addr] <= poke_data;
    else if (exec_wr_req) env_mem[exec_wr_addr] <= exec_wr_data;
    if (exec_rd_req) exec_rd_data <= env_mem[exec_rd_addr];
  end

  // reference machine state
  int m_ac, m_l, m_pc;
  int ref_mem [4096];

  typedef struct {
    int kind; int addr; int data; int ac; int lk; int pc; int stalls;
  } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad = 0;
  int prev_stall = 0;
  int stall_cnt = 0;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0o want %0o", nm, act, want);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int data, input int stalls);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.stalls = stalls;
    e.ac = m_ac; e.lk = m_l; e.pc = m_pc;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d want nothing", kind);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      bad++;
      $display("FAIL event_order: got kind %0d want kind %0d", kind, e.kind);
      return;
    end
    case (kind)
      EV_RD: begin
        $display("read  addr=%04o", exec_rd_addr);
        if (int'(exec_rd_addr) != e.addr) begin
          bad++;
          $display("FAIL rd_addr: got %04o want %04o", exec_rd_addr, e.addr);
        end
      end
      EV_WR: begin
        $display("write addr=%04o data=%04o", exec_wr_addr, exec_wr_data);
        if (int'(exec_wr_addr) != e.addr || int'(exec_wr_data) != e.data) begin
          bad++;
          $display("FAIL wr: got addr %04o data %04o want addr %04o data %04o",
                   exec_wr_addr, exec_wr_data, e.addr, e.data);
        end
      end
      default: begin
        $display("done  pc=%04o ac=%04o l=%0d stalls=%0d", PC_value, intAcc, intLink, stall_cnt);
        if (int'(PC_value) != e.pc || int'(intAcc) != e.ac || int'(intLink) != e.lk ||
            stall_cnt != e.stalls) begin
          bad++;
          $display("FAIL done: got pc %04o ac %04o l %0d stalls %0d want pc %04o ac %04o l %0d stalls %0d",
                   PC_value, intAcc, intLink, stall_cnt, e.pc, e.ac, e.lk, e.stalls);
        end
      end
    endcase
  endtask

  // monitor: every strobe and every stall fall must match the next expectation
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
      stall_cnt  = 0;
    end else begin
      if (exec_rd_req && exec_wr_req) begin
        total++; bad++;
        $display("FAIL strobe_overlap: got rd=1 wr=1 want at most one");
      end
      if (exec_rd_req) check_ev(EV_RD);
      if (exec_wr_req) check_ev(EV_WR);
      if (stall) stall_cnt++;
      else if (prev_stall != 0) begin
        check_ev(EV_DONE);
        stall_cnt = 0;
      end
      prev_stall = int'(stall);
    end
  end

  task automatic model_op7(input pdp_op7_opcode_s o);
    int v, n;
    bit right;
    if (o.CLA) m_ac = 0;
    if (o.CLL) m_l = 0;
    if (o.CMA) m_ac = 4095 - m_ac;
    if (o.CML) m_l = 1 - m_l;
    if (o.IAC) begin
      m_ac = m_ac + 1;
      if (m_ac == 4096) begin m_ac = 0; m_l = 1 - m_l; end
    end
    n = 0; right = 0;
    if (o.RAR) begin n = 1; right = 1; end
    else if (o.RTR) begin n = 2; right = 1; end
    else if (o.RAL) n = 1;
    else if (o.RTL) n = 2;
    v = m_l * 4096 + m_ac;
    for (int k = 0; k < n; k++)
      v = right ? ((v >> 1) | ((v & 1) << 12)) : (((v << 1) & 8191) | (v >> 12));
    m_l = v >> 12;
    m_ac = v & 4095;
  endtask

  // apply one instruction to the reference machine and queue its responses
  task automatic model_step(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o, input int a);
    int v;
    bit any7;
    any7 = o.CLA | o.CLL | o.CMA | o.CML | o.IAC | o.RAR | o.RTR | o.RAL | o.RTL | o.HLT;
    if (m.AND) begin
      push_ev(EV_RD, a, 0, 0);
      m_ac = m_ac & ref_mem[a]; m_pc = (m_pc + 1) % 4096;
      push_ev(EV_DONE, 0, 0, 2);
    end else if (m.TAD) begin
      push_ev(EV_RD, a, 0, 0);
      v = m_ac + ref_mem[a];
      if (v > 4095) m_l = 1 - m_l;
      m_ac = v % 4096; m_pc = (m_pc + 1) % 4096;
      push_ev(EV_DONE, 0, 0, 2);
    end else if (m.ISZ) begin
      v = (ref_mem[a] + 1) % 4096;
      push_ev(EV_RD, a, 0, 0);
      push_ev(EV_WR, a, v, 0);
      ref_mem[a] = v;
      m_pc = (m_pc + ((v == 0) ? 2 : 1)) % 4096;
      push_ev(EV_DONE, 0, 0, 3);
    end else if (m.DCA) begin
      push_ev(EV_WR, a, m_ac, 0);
      ref_mem[a] = m_ac; m_ac = 0; m_pc = (m_pc + 1) % 4096;
      push_ev(EV_DONE, 0, 0, 1);
    end else if (m.JMS) begin
      v = (m_pc + 1) % 4096;
      push_ev(EV_WR, a, v, 0);
      ref_mem[a] = v; m_pc = (a + 1) % 4096;
      push_ev(EV_DONE, 0, 0, 1);
    end else if (m.JMP) begin
      m_pc = a;
      push_ev(EV_DONE, 0, 0, 1);
    end else if (any7) begin
      model_op7(o);
      m_pc = (m_pc + 1) % 4096;
      if (!o.HLT) push_ev(EV_DONE, 0, 0, 1);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (stall && n < 40) begin @(negedge clk); n++; end
    if (stall) begin
      total++; bad++;
      $display("FAIL ready_timeout: got stall 1 want 0 within 40 cycles");
    end
  endtask

  task automatic drive(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o, input logic [11:0] a);
    mem_op = m; op7_op = o; base_addr = a;
    @(posedge clk); #1;
    mem_op = '0; op7_op = '0; base_addr = '0;
  endtask

  task automatic issue(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o, input int a);
    wait_ready();
    model_step(m, o, a);
    drive(m, o, 12'(a));
  endtask

  task automatic mem_instr(input int k, input int a);
    logic [6:0] mb;
    mb = 7'b1000000 >> k;
    issue(pdp_mem_opcode_s'(mb), '0, a);
  endtask

  task automatic op7_instr(input logic [10:0] ob);
    issue('0, pdp_op7_opcode_s'(ob), 0);
  endtask

  task automatic poke(input int a, input int d);
    wait_ready();
    poke_en = 1'b1; poke_addr = 12'(a); poke_data = 12'(d);
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0 || PC_value !== 12'o0200 || intAcc !== 12'o0 || intLink !== 1'b0 ||
        exec_rd_req !== 1'b0 || exec_wr_req !== 1'b0 || exec_rd_addr !== 12'o0 ||
        exec_wr_addr !== 12'o0 || exec_wr_data !== 12'o0) begin
      bad++;
      $display("FAIL reset_values: got stall %b pc %04o ac %04o l %b rd %b wr %b want 0 0200 0 0 0 0",
               stall, PC_value, intAcc, intLink, exec_rd_req, exec_wr_req);
    end
    exp_q.delete();
    m_ac = 0; m_l = 0; m_pc = 'o200;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rand_instr();
    logic [6:0]  mb;
    logic [10:0] ob;
    int k, a;
    a  = $urandom_range(0, 4095);
    k  = $urandom_range(0, 10);
    mb = '0;
    ob = 11'($urandom) & 11'h7FD;
    if (k <= 5) begin
      mb = 7'b1000000 >> k;
      if ($urandom_range(0, 3) == 0) mb = mb | 7'($urandom);
      if ($urandom_range(0, 1) == 0) ob = '0;
    end else if (k <= 9) begin
      if (ob[10:2] == '0) ob = ob | O_IAC;
      mb = 7'($urandom_range(0, 1));
    end else begin
      mb = 7'b0000001;
      ob = 11'b00000000001;
    end
    issue(pdp_mem_opcode_s'(mb), pdp_op7_opcode_s'(ob), a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    // preload memory while the DUT is held in reset
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      poke_en = 1'b1; poke_addr = 12'(i); poke_data = 12'($urandom);
      ref_mem[i] = int'(poke_data);
    end
    @(negedge clk);
    poke_en = 1'b0;
    do_reset();

    // idle after reset
    repeat (5) @(negedge clk);
    chk("idle_pc", int'(PC_value), 'o200);
    chk("idle_stall", int'(stall), 0);
    chk("idle_ac", int'(intAcc), 0);
    chk("idle_link", int'(intLink), 0);

    // TAD with carry out of 7777
    poke('o100, 1);
    op7_instr(O_CMA);
    mem_instr(I_TAD, 'o100);
    wait_ready();
    chk("tad_ac", int'(intAcc), 0);
    chk("tad_link", int'(intLink), 1);

    // ISZ wrap-to-zero skips, ordinary increment does not
    poke('o50, 'o7777);
    mem_instr(I_ISZ, 'o50);
    poke('o50, 'o5);
    mem_instr(I_ISZ, 'o50);

    // DCA then JMS
    mem_instr(I_DCA, 'o70);
    poke('o71, 'o1234);
    mem_instr(I_TAD, 'o71);
    mem_instr(I_DCA, 'o60);
    mem_instr(I_JMS, 'o300);

    // CLA CLL CMA IAC: increment carry flips the cleared link
    op7_instr(O_CLA | O_CLL | O_CMA | O_IAC);
    wait_ready();
    chk("op7_ac", int'(intAcc), 0);
    chk("op7_link", int'(intLink), 1);

    // rotate two left through the link
    op7_instr(O_CLA | O_CLL);
    poke('o72, 'o4001);
    mem_instr(I_TAD, 'o72);
    op7_instr(O_RTL);

    // NOP-only presentations are ignored
    issue(pdp_mem_opcode_s'(7'b0000001), pdp_op7_opcode_s'(11'b1), 'o123);

    // random instruction stream
    for (int n = 0; n < 300; n++) rand_instr();

    // reset in ISZ read-wait abandons the write
    wait_ready();
    poke('o50, 'o17);
    wait_ready();
    push_ev(EV_RD, 'o50, 0, 0);
    drive(pdp_mem_opcode_s'(7'b0010000), '0, 12'o0050);
    @(posedge clk); #2;
    do_reset();
    repeat (6) @(negedge clk);
    chk("isz_abandon_mem", int'(env_mem['o50]), ref_mem['o50]);
    chk("isz_abandon_pc", int'(PC_value), 'o200);
    mem_instr(I_JMP, 'o400);
    wait_ready();
    chk("jmp_after_reset_pc", int'(PC_value), 'o400);

    // halt holds stall until reset
    op7_instr(O_CLA | O_IAC | O_HLT);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("halt_stall", int'(stall), 1);
    end
    chk("halt_pc", int'(PC_value), m_pc);
    chk("halt_ac", int'(intAcc), m_ac);
    do_reset();
    repeat (3) @(negedge clk);
    chk("post_halt_stall", int'(stall), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
